// File: rtl/game_pkg.sv
// ============================================================================
//  game_pkg : shared grid geometry and loader state encoding
//  Rev 1.0
// ============================================================================
`default_nettype none

package game_pkg;

   localparam int P_N    = 400;
   localparam int P_M    = 300;
   localparam int CELLS  = P_N * P_M;
   localparam int ADDR_W = 24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_UNPACK = 3'd2,
      ST_CLEAR  = 3'd3,
      ST_DONE   = 3'd4
   } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/pattern_loader.sv
// ============================================================================
//  pattern_loader : fills or clears the cell grid, one single-bit write/cycle
//  Rev 1.0
// ============================================================================
`default_nettype none

module pattern_loader
   import game_pkg::*;
#(
   parameter int P_N         = game_pkg::P_N,
   parameter int P_M         = game_pkg::P_M,
   parameter int ADDR_W      = game_pkg::ADDR_W,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk_vga,
   input  logic              reset_btn,
   input  logic              load_req,
   input  logic              clear_req,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int                C_CELLS = P_N * P_M;
   localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(C_CELLS - 1);
   localparam int                C_TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYC - 1);

   loader_state_t        r_state;
   logic [ADDR_W-1:0]    r_cnt;
   logic [7:0]           r_shift;
   logic [2:0]           r_bit_idx;
   logic [C_TMO_W-1:0]   r_tmo;

   // r_cnt always holds the address of the write currently on the port
   assign wr_addr = r_cnt;
   assign busy    = (r_state != ST_IDLE);

   always_ff @(posedge clk_vga or posedge reset_btn) begin
      if (reset_btn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_tmo      <= '0;
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         wr_data    <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clear_req) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  error   <= 1'b0;
                  wr_en   <= 1'b1;
                  wr_data <= 1'b0;
               end else if (load_req) begin
                  r_state    <= ST_FETCH;
                  r_cnt      <= '0;
                  error      <= 1'b0;
                  r_tmo      <= '0;
                  byte_ready <= 1'b1;
               end
            end

            ST_CLEAR: begin
               if (r_cnt == C_LAST) begin
                  r_state <= ST_DONE;
                  wr_en   <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + ADDR_W'(1);
               end
            end

            ST_FETCH: begin
               if (byte_valid && byte_ready) begin
                  r_state    <= ST_UNPACK;
                  r_shift    <= byte_data;
                  r_bit_idx  <= '0;
                  r_tmo      <= '0;
                  byte_ready <= 1'b0;
                  wr_en      <= 1'b1;
                  wr_data    <= byte_data[0];
               end else if (r_tmo == C_TMO_LAST) begin
                  r_state    <= ST_DONE;
                  byte_ready <= 1'b0;
                  error      <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + C_TMO_W'(1);
               end
            end

            ST_UNPACK: begin
               // The grid end may fall mid-byte; leftover bits are dropped
               if (r_cnt == C_LAST) begin
                  r_state <= ST_DONE;
                  wr_en   <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + ADDR_W'(1);
                  if (r_bit_idx == 3'd7) begin
                     r_state    <= ST_FETCH;
                     r_tmo      <= '0;
                     wr_en      <= 1'b0;
                     byte_ready <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     wr_data   <= r_shift[1];
                  end
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state    <= ST_IDLE;
               byte_ready <= 1'b0;
               wr_en      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pattern_loader.sv
// ============================================================================
//  tb_pattern_loader : scoreboard bench for pattern_loader on a 9x4 grid
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pattern_loader;

   localparam int TB_N     = 9;
   localparam int TB_M     = 4;
   localparam int TB_CELLS = TB_N * TB_M;
   localparam int TB_TMO   = 100;

   logic        clk_vga = 1'b0;
   logic        reset_btn = 1'b1;
   logic        load_req = 1'b0;
   logic        clear_req = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        wr_en;
   logic [23:0] wr_addr;
   logic        wr_data;
   logic        busy;
   logic        done;
   logic        error;

   pattern_loader #(
      .P_N(TB_N), .P_M(TB_M), .ADDR_W(24), .TIMEOUT_CYC(TB_TMO)
   ) dut (
      .clk_vga(clk_vga), .reset_btn(reset_btn),
      .load_req(load_req), .clear_req(clear_req),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk_vga = ~clk_vga;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          wr_count = 0;
   bit          sb_on = 1'b1;
   logic [24:0] exp_q[$];
   int          xfer_cyc[$];
   logic [7:0]  pat[5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};

   always @(posedge clk_vga) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every write on the port is matched against the scoreboard
   always @(negedge clk_vga) begin
      logic [24:0] e;
      if (wr_en) begin
         wr_count++;
         check("ready_during_write", {31'd0, byte_ready}, 32'd0);
         if (sb_on) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=addr %0d required=none", wr_addr);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", {8'd0, wr_addr}, {8'd0, e[24:1]});
               check("wr_data", {31'd0, wr_data}, {31'd0, e[0]});
            end
         end
      end
   end

   task automatic push_clear();
      for (int c = 0; c < TB_CELLS; c++) exp_q.push_back({24'(c), 1'b0});
   endtask

   task automatic push_load(input int ncells);
      logic [7:0] b;
      for (int c = 0; c < ncells; c++) begin
         b = pat[c / 8];
         exp_q.push_back({24'(c), b[c % 8]});
      end
   endtask

   task automatic req(input bit ld, input bit cl);
      @(negedge clk_vga);
      load_req  = ld;
      clear_req = cl;
      @(negedge clk_vga);
      load_req  = 1'b0;
      clear_req = 1'b0;
   endtask

   // n = 1 is the first cycle after the request edge
   task automatic wait_done(output int n, input bit inject_load, output bit saw_ready);
      n = 1;
      saw_ready = 1'b0;
      while (!done && n < 2000) begin
         if (byte_ready) saw_ready = 1'b1;
         load_req = inject_load && (n == 5);
         @(negedge clk_vga);
         n++;
      end
      load_req = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done within 2000 cycles");
      end
   endtask

   task automatic send_bytes(input int nb, input int gapmax);
      int gap;
      int b;
      for (int i = 0; i < nb; i++) begin
         gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk_vga);
         end
         byte_valid = 1'b1;
         byte_data  = pat[i];
         b = 0;
         while (!byte_ready && b < 3000) begin
            @(negedge clk_vga);
            b++;
         end
         if (!byte_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_accept actual=not_ready required=ready byte %0d", i);
            byte_valid = 1'b0;
            return;
         end
         xfer_cyc.push_back(cyc);
         @(negedge clk_vga);
      end
      byte_valid = 1'b0;
   endtask

   task automatic post_check(input string tag);
      @(negedge clk_vga);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int n;
      bit saw;
      int wc;
      int b;

      repeat (3) @(negedge clk_vga);
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_wr_en",      {31'd0, wr_en},      32'd0);
      check("rst_wr_addr",    {8'd0, wr_addr},     32'd0);
      check("rst_wr_data",    {31'd0, wr_data},    32'd0);
      check("rst_busy",       {31'd0, busy},       32'd0);
      check("rst_done",       {31'd0, done},       32'd0);
      check("rst_error",      {31'd0, error},      32'd0);
      reset_btn = 1'b0;
      @(negedge clk_vga);

      // Simultaneous load+clear: clear wins; a load during CLEAR is ignored
      push_clear();
      req(1'b1, 1'b1);
      check("clear_busy", {31'd0, busy}, 32'd1);
      wait_done(n, 1'b1, saw);
      check("clear_done_latency", n, TB_CELLS + 1);
      check("clear_no_ready", {31'd0, saw}, 32'd0);
      post_check("clear");

      // Continuous stream, final byte only partially used
      push_load(TB_CELLS);
      xfer_cyc.delete();
      req(1'b1, 1'b0);
      fork
         send_bytes(5, 0);
         wait_done(n, 1'b0, saw);
      join
      check("load_done_latency", n, 42);
      check("load_xfers", xfer_cyc.size(), 5);
      for (int i = 1; i < 5; i++)
         if (i < xfer_cyc.size())
            check("load_byte_spacing", xfer_cyc[i] - xfer_cyc[i-1], 9);
      post_check("load");

      // Same data with random source gaps
      push_load(TB_CELLS);
      xfer_cyc.delete();
      req(1'b1, 1'b0);
      fork
         send_bytes(5, 6);
         wait_done(n, 1'b0, saw);
      join
      check("bp_xfers", xfer_cyc.size(), 5);
      check("bp_error", {31'd0, error}, 32'd0);
      post_check("bp");

      // Stream stalls after 3 bytes
      push_load(24);
      req(1'b1, 1'b0);
      send_bytes(3, 0);
      wait_done(n, 1'b0, saw);
      check("tmo_latency", n, 8 + TB_TMO + 1);
      check("tmo_error_with_done", {31'd0, error}, 32'd1);
      post_check("tmo");
      check("tmo_error_sticky", {31'd0, error}, 32'd1);
      push_clear();
      req(1'b0, 1'b1);
      check("tmo_error_cleared", {31'd0, error}, 32'd0);
      wait_done(n, 1'b0, saw);
      check("clear2_done_latency", n, TB_CELLS + 1);
      post_check("clear2");

      // Asynchronous reset in the middle of a clear
      sb_on = 1'b0;
      req(1'b0, 1'b1);
      b = 0;
      while (!(wr_en && wr_addr == 24'd20) && b < 100) begin
         @(negedge clk_vga);
         b++;
      end
      check("rst_mid_reached", {8'd0, wr_addr}, 32'd20);
      #2 reset_btn = 1'b1;
      #1;
      check("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_mid_busy",  {31'd0, busy},  32'd0);
      check("rst_mid_addr",  {8'd0, wr_addr}, 32'd0);
      @(negedge clk_vga);
      reset_btn = 1'b0;
      wc = wr_count;
      repeat (20) @(negedge clk_vga);
      check("rst_no_writes", wr_count - wc, 32'd0);
      check("rst_idle_busy", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
